// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1024x768 @ 60 Hz (65 MHz pclk) timing constants shared by
// the timing generator and the downstream draw stages.
//   CNT_W               : width of hcount/vcount (12 bits, totals <= 4096)
//   H_/V_ VISIBLE, FRONT, SYNC, TOTAL : raw timing values
//   H_/V_ SYNC_START/END : inclusive sync-pulse bounds derived from the above
package vga_timing_pkg;

   localparam int unsigned CNT_W = 12;

   localparam int unsigned H_VISIBLE = 1024;
   localparam int unsigned H_FRONT   = 24;
   localparam int unsigned H_SYNC    = 136;
   localparam int unsigned H_TOTAL   = 1344;

   localparam int unsigned V_VISIBLE = 768;
   localparam int unsigned V_FRONT   = 3;
   localparam int unsigned V_SYNC    = 6;
   localparam int unsigned V_TOTAL   = 806;

   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-stream timing bundle from the timing generator to the
// draw stages.
//   hcount_out/vcount_out : 12-bit pixel column / line
//   hsync_out/vsync_out   : active-high sync pulses
//   hblnk_out/vblnk_out   : blanking flags
//   frame_start_out/frame_cnt_out : present only with VGA_TIMING_FRAME_CNT_EN
// modport master = driver (timing generator), slave = consumer.
interface vga_timing_if;
   import vga_timing_pkg::*;

   cnt_t hcount_out;
   logic hsync_out;
   logic hblnk_out;
   cnt_t vcount_out;
   logic vsync_out;
   logic vblnk_out;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic        frame_start_out;
   logic [15:0] frame_cnt_out;

   modport master (output hcount_out, hsync_out, hblnk_out,
                   vcount_out, vsync_out, vblnk_out,
                   frame_start_out, frame_cnt_out);
   modport slave  (input  hcount_out, hsync_out, hblnk_out,
                   vcount_out, vsync_out, vblnk_out,
                   frame_start_out, frame_cnt_out);
`else
   modport master (output hcount_out, hsync_out, hblnk_out,
                   vcount_out, vsync_out, vblnk_out);
   modport slave  (input  hcount_out, hsync_out, hblnk_out,
                   vcount_out, vsync_out, vblnk_out);
`endif

endinterface

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis (horizontal or vertical). Wrapping counter
// with registered blank/sync flags decoded from the next count, so each flag
// changes on the same edge as the count it describes.
//   clk, rst   : clock, synchronous active-high reset (all outputs to 0)
//   en         : advance the count this cycle
//   count_out  : registered count, 0..TOTAL-1
//   blank_out  : registered, count >= VISIBLE
//   sync_out   : registered, SYNC_START <= count <= SYNC_END
//   wrap_out   : combinational, high when the next edge wraps TOTAL-1 -> 0
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int unsigned VISIBLE    = H_VISIBLE,
   parameter int unsigned SYNC_START = H_SYNC_START,
   parameter int unsigned SYNC_END   = H_SYNC_END,
   parameter int unsigned TOTAL      = H_TOTAL
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output cnt_t count_out,
   output logic blank_out,
   output logic sync_out,
   output logic wrap_out
);

   localparam cnt_t LAST = cnt_t'(TOTAL - 1);
   localparam cnt_t VIS  = cnt_t'(VISIBLE);
   localparam cnt_t SS   = cnt_t'(SYNC_START);
   localparam cnt_t SE   = cnt_t'(SYNC_END);

   cnt_t count_q, count_d;
   logic blank_q, blank_d;
   logic sync_q,  sync_d;

   always_comb begin
      count_d  = count_q;
      wrap_out = en && (count_q == LAST);
      if (en) begin
         count_d = wrap_out ? '0 : count_q + 1'b1;
      end
      // Flags decode the next count so they register together with it.
      blank_d = (count_d >= VIS);
      sync_d  = (count_d >= SS) && (count_d <= SE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         blank_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign count_out = count_q;
   assign blank_out = blank_q;
   assign sync_out  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source of the pixel-stream timing (default 1024x768 @ 60 Hz).
// Two vga_axis_cnt instances; the horizontal wrap strobe enables the vertical
// axis, so vcount steps on the same edge hcount goes TOTAL-1 -> 0.
//   pclk : pixel clock, rising edge
//   rst  : synchronous active-high reset, all outputs to 0
//   tim  : vga_timing_if.master carrying counts, syncs and blanks (all registered)
// Optional macro VGA_TIMING_FRAME_CNT_EN adds frame_start_out (one-cycle pulse
// at (0,0) after a frame wrap) and frame_cnt_out (16-bit frame counter).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_TOTAL   = vga_timing_pkg::H_TOTAL,
   parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_TOTAL   = vga_timing_pkg::V_TOTAL
) (
   input  logic        pclk,
   input  logic        rst,
   vga_timing_if.master tim
);

   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   cnt_t hcount, vcount;
   logic hsync, hblnk, vsync, vblnk;
   logic h_wrap, v_wrap;

   vga_axis_cnt #(
      .VISIBLE    (H_VISIBLE),
      .SYNC_START (HS_START),
      .SYNC_END   (HS_END),
      .TOTAL      (H_TOTAL)
   ) u_h_cnt (
      .clk       (pclk),
      .rst       (rst),
      .en        (1'b1),
      .count_out (hcount),
      .blank_out (hblnk),
      .sync_out  (hsync),
      .wrap_out  (h_wrap)
   );

   vga_axis_cnt #(
      .VISIBLE    (V_VISIBLE),
      .SYNC_START (VS_START),
      .SYNC_END   (VS_END),
      .TOTAL      (V_TOTAL)
   ) u_v_cnt (
      .clk       (pclk),
      .rst       (rst),
      .en        (h_wrap),
      .count_out (vcount),
      .blank_out (vblnk),
      .sync_out  (vsync),
      .wrap_out  (v_wrap)
   );

   assign tim.hcount_out = hcount;
   assign tim.hsync_out  = hsync;
   assign tim.hblnk_out  = hblnk;
   assign tim.vcount_out = vcount;
   assign tim.vsync_out  = vsync;
   assign tim.vblnk_out  = vblnk;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic        frame_start_q, frame_start_d;
   logic [15:0] frame_cnt_q,   frame_cnt_d;

   // v_wrap is only true together with h_wrap, i.e. on the (last,last) -> (0,0)
   // edge, so registering it aligns the pulse with counts at (0,0).
   always_comb begin
      frame_start_d = v_wrap;
      frame_cnt_d   = frame_cnt_q;
      if (v_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign tim.frame_start_out = frame_start_q;
   assign tim.frame_cnt_out   = frame_cnt_q;
`else
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   logic pclk = 1'b0;
   logic rst_full  = 1'b1;
   logic rst_small = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 pclk = ~pclk;

   vga_timing_if full_if ();
   vga_timing_if small_if ();

   // Full 1024x768 timing: used for reset release and a complete line.
   vga_timing_gen dut_full (
      .pclk (pclk),
      .rst  (rst_full),
      .tim  (full_if)
   );

   // Scaled timing so whole frames fit in a short run:
   // H: blank 16..23, sync 18..21, total 24; V: blank 8..11, sync 9..10, total 12.
   vga_timing_gen #(
      .H_VISIBLE (16),
      .H_FRONT   (2),
      .H_SYNC    (4),
      .H_TOTAL   (24),
      .V_VISIBLE (8),
      .V_FRONT   (1),
      .V_SYNC    (2),
      .V_TOTAL   (12)
   ) dut_small (
      .pclk (pclk),
      .rst  (rst_small),
      .tim  (small_if)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic check_small_zero(input string tag);
      check({tag, "_h"},     32'(small_if.hcount_out), 0);
      check({tag, "_v"},     32'(small_if.vcount_out), 0);
      check({tag, "_hsync"}, 32'(small_if.hsync_out),  0);
      check({tag, "_hblnk"}, 32'(small_if.hblnk_out),  0);
      check({tag, "_vsync"}, 32'(small_if.vsync_out),  0);
      check({tag, "_vblnk"}, 32'(small_if.vblnk_out),  0);
   endtask

   initial begin
      int unsigned exp_h;
      int unsigned exp_v;
      int unsigned hs_len;
      int unsigned frames;
      int unsigned starts;
      int unsigned last_zero;
      bit          seen_zero;
      bit          reached;

      // ---- reset held 5 cycles: everything zero ----
      tick(5);
      check("rst_full_h",     32'(full_if.hcount_out), 0);
      check("rst_full_v",     32'(full_if.vcount_out), 0);
      check("rst_full_hsync", 32'(full_if.hsync_out),  0);
      check("rst_full_hblnk", 32'(full_if.hblnk_out),  0);
      check("rst_full_vsync", 32'(full_if.vsync_out),  0);
      check("rst_full_vblnk", 32'(full_if.vblnk_out),  0);
      check_small_zero("rst_small");

      // ---- release: hcount 1 then 2 ----
      rst_full = 1'b0;
      tick(1);
      check("rel_h1", 32'(full_if.hcount_out), 1);
      tick(1);
      check("rel_h2", 32'(full_if.hcount_out), 2);

      // ---- rest of line 0 at full timing, through the wrap ----
      exp_h  = 2;
      hs_len = 0;
      for (int i = 0; i < 1342; i++) begin
         tick(1);
         exp_h = (exp_h == 1343) ? 0 : exp_h + 1;
         check("line_h",     32'(full_if.hcount_out), exp_h);
         check("line_hblnk", 32'(full_if.hblnk_out),  (exp_h >= 1024) ? 1 : 0);
         check("line_hsync", 32'(full_if.hsync_out),
               (exp_h >= 1048 && exp_h <= 1183) ? 1 : 0);
         check("line_v",     32'(full_if.vcount_out), (exp_h == 0) ? 1 : 0);
         if (full_if.hsync_out) hs_len++;
      end
      check("hsync_width", hs_len, 136);
      check("line_vblnk", 32'(full_if.vblnk_out), 0);
      check("line_vsync", 32'(full_if.vsync_out), 0);

      // ---- scaled instance: three full frames against a reference model ----
      check_small_zero("held_small");
      rst_small = 1'b0;
      exp_h = 0; exp_v = 0;
      frames = 0; starts = 0; seen_zero = 0; last_zero = 0;
      for (int unsigned cyc = 1; cyc <= 3 * 288; cyc++) begin
         tick(1);
         if (exp_h == 23) begin
            exp_h = 0;
            if (exp_v == 11) begin
               exp_v = 0;
               frames++;
            end else begin
               exp_v++;
            end
         end else begin
            exp_h++;
         end
         check("frm_h",     32'(small_if.hcount_out), exp_h);
         check("frm_v",     32'(small_if.vcount_out), exp_v);
         check("frm_hblnk", 32'(small_if.hblnk_out),  (exp_h >= 16) ? 1 : 0);
         check("frm_hsync", 32'(small_if.hsync_out),  (exp_h >= 18 && exp_h <= 21) ? 1 : 0);
         check("frm_vblnk", 32'(small_if.vblnk_out),  (exp_v >= 8) ? 1 : 0);
         check("frm_vsync", 32'(small_if.vsync_out),  (exp_v >= 9 && exp_v <= 10) ? 1 : 0);
         if (small_if.hcount_out == 0 && small_if.vcount_out == 0) begin
            if (seen_zero) check("frame_period", cyc - last_zero, 288);
            seen_zero = 1;
            last_zero = cyc;
         end
`ifdef VGA_TIMING_FRAME_CNT_EN
         check("frame_start", 32'(small_if.frame_start_out),
               (exp_h == 0 && exp_v == 0) ? 1 : 0);
         check("frame_cnt_run", 32'(small_if.frame_cnt_out), frames);
         if (small_if.frame_start_out) starts++;
`endif
      end
      check("frames_seen", frames, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("frame_start_pulses", starts, 3);
      check("frame_cnt_3", 32'(small_if.frame_cnt_out), 3);
`endif

      // ---- run to (20,9), both syncs active, then reset for one cycle ----
      reached = 0;
      for (int i = 0; i < 400 && !reached; i++) begin
         tick(1);
         if (small_if.hcount_out == 20 && small_if.vcount_out == 9) reached = 1;
      end
      check("reach_sync_point", 32'(reached), 1);
      check("mid_hsync_on", 32'(small_if.hsync_out), 1);
      check("mid_vsync_on", 32'(small_if.vsync_out), 1);
      rst_small = 1'b1;
      tick(1);
      check_small_zero("mid_rst");
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("mid_rst_fstart", 32'(small_if.frame_start_out), 0);
      check("mid_rst_fcnt",   32'(small_if.frame_cnt_out),   0);
`endif
      rst_small = 1'b0;
      tick(1);
      check("restart_h1", 32'(small_if.hcount_out), 1);
      check("restart_v0", 32'(small_if.vcount_out), 0);
      tick(1);
      check("restart_h2", 32'(small_if.hcount_out), 2);
      check("restart_hsync", 32'(small_if.hsync_out), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
